// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Define BIN_TO_BCD_BLANK_EN to add the leading-zero blank mask output.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN_TO_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_e;

  state_e           state_q;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    work_q, work_d, adj;
  logic             sticky_q, sticky_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last;
  logic             busy_q, done_q, ovf_q;
  logic [BW-1:0]    bcd_q;

  always_comb begin
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
    work_d   = {adj[BW-2:0], sh_q[BIN_W-1]};
    sh_d     = sh_q << 1;
    sticky_d = sticky_q | adj[BW-1];
    cnt_d    = cnt_q + CW'(1);
    last     = (cnt_q == LAST);
  end

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_run;

  // A digit blanks only if it and every digit above it are zero.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (work_d[4*k +: 4] == 4'd0);
      blank_d[k] = zero_run;
    end
    if (sticky_d)
      blank_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blank_q <= ~DIGITS'(1);
    else if (state_q == CONV && last)
      blank_q <= blank_d;
  end

  assign blank = blank_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      sh_q     <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sh_q     <= bin;
            work_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CONV;
          end
        end
        CONV: begin
          sh_q     <= sh_d;
          work_q   <= work_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_d;
          if (last) begin
            bcd_q   <= work_d;
            ovf_q   <= sticky_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: two converters (3 and 2 digits) share one stimulus stream.
// Blank mask is checked when BIN_TO_BCD_BLANK_EN is defined.
module tb_bin_to_bcd_seq;
  localparam int BW = 8;
  localparam int DA = 3;
  localparam int DB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [BW-1:0] bin = '0;

  logic busy_a, done_a, ovf_a;
  logic busy_b, done_b, ovf_b;
  logic [4*DA-1:0] bcd_a;
  logic [4*DB-1:0] bcd_b;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [DA-1:0] blank_a;
  logic [DB-1:0] blank_b;
`endif

  bin_to_bcd_seq #(.BIN_W(BW), .DIGITS(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
`ifdef BIN_TO_BCD_BLANK_EN
    , .blank(blank_a)
`endif
  );

  bin_to_bcd_seq #(.BIN_W(BW), .DIGITS(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
`ifdef BIN_TO_BCD_BLANK_EN
    , .blank(blank_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int     val;
    longint cyc;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint acc_cyc = 0;
  int     cnt = 0;
  int     accepts = 0;
  int     hold_a = 0;
  int     hold_b = 0;

  function automatic logic [39:0] to_bcd(int v, int d);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit ovf_of(int v, int d);
    return v >= 10 ** d;
  endfunction

  function automatic logic [9:0] blank_of(int v, int d);
    logic [9:0] r;
    r = '0;
    if (!ovf_of(v, d))
      for (int k = 1; k < d; k++)
        r[k] = (v < 10 ** k);
    return r;
  endfunction

  task automatic check(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // Reference timing: accept when idle, result BW edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0;
      qa.delete();
      qb.delete();
      hold_a = 0;
      hold_b = 0;
    end else begin
      cyc++;
      if (cnt == 0) begin
        if (start) begin
          qa.push_back('{int'(bin), cyc + BW});
          qb.push_back('{int'(bin), cyc + BW});
          cnt = BW;
          acc_cyc = cyc;
          accepts++;
        end
      end else begin
        cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("busy_a", 64'(busy_a), 64'(cnt != 0));
      check("busy_b", 64'(busy_b), 64'(cnt != 0));
      if (done_a) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_a_spurious: got done expected none at cycle %0d", cyc);
        end else begin
          e = qa.pop_front();
          check("latency_a", 64'(cyc), 64'(e.cyc));
          hold_a = e.val;
        end
      end else if (qa.size() != 0 && cyc >= qa[0].cyc) begin
        e = qa.pop_front();
        tests++; fails++;
        $display("FAIL done_a_missing: got none expected done for %0d", e.val);
      end
      if (done_b) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_b_spurious: got done expected none at cycle %0d", cyc);
        end else begin
          e = qb.pop_front();
          check("latency_b", 64'(cyc), 64'(e.cyc));
          hold_b = e.val;
        end
      end else if (qb.size() != 0 && cyc >= qb[0].cyc) begin
        e = qb.pop_front();
        tests++; fails++;
        $display("FAIL done_b_missing: got none expected done for %0d", e.val);
      end
      check("bcd_a", 64'(bcd_a), 64'(to_bcd(hold_a, DA)));
      check("ovf_a", 64'(ovf_a), 64'(ovf_of(hold_a, DA)));
      check("bcd_b", 64'(bcd_b), 64'(to_bcd(hold_b, DB)));
      check("ovf_b", 64'(ovf_b), 64'(ovf_of(hold_b, DB)));
`ifdef BIN_TO_BCD_BLANK_EN
      check("blank_a", 64'(blank_a), 64'(blank_of(hold_a, DA)));
      check("blank_b", 64'(blank_b), 64'(blank_of(hold_b, DB)));
`endif
    end
  end

  task automatic wait_accept(int a0);
    int i;
    for (i = 0; i < 40 && accepts == a0; i++) begin
      @(posedge clk);
      #1;
    end
    if (accepts == a0) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no accept expected one");
    end
  endtask

  task automatic issue(int v);
    int a0;
    a0 = accepts;
    bin = BW'(v);
    start = 1'b1;
    wait_accept(a0);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      if (cnt == 0 && qa.size() == 0 && qb.size() == 0)
        break;
      @(posedge clk);
      #1;
    end
    if (i >= 100) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, 64'(busy_a), 64'(0));
    check({tag, "_done"}, 64'(done_a), 64'(0));
    check({tag, "_bcd_a"}, 64'(bcd_a), 64'(0));
    check({tag, "_ovf_a"}, 64'(ovf_a), 64'(0));
    check({tag, "_bcd_b"}, 64'(bcd_b), 64'(0));
`ifdef BIN_TO_BCD_BLANK_EN
    check({tag, "_blank_a"}, 64'(blank_a), 64'(3'b110));
    check({tag, "_blank_b"}, 64'(blank_b), 64'(2'b10));
`endif
  endtask

  initial begin
    longint prev;
    int a0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    issue(255);
    wait_idle();
    issue(0);
    wait_idle();
    issue(100);
    wait_idle();
    issue(99);
    wait_idle();
    issue(5);
    wait_idle();
    issue(42);
    wait_idle();
    issue(200);
    wait_idle();

    // Sweep with start held high: one accept every BW+1 cycles.
    prev = 0;
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      a0 = accepts;
      bin = BW'(v);
      wait_accept(a0);
      if (v > 0)
        check("sweep_period", 64'(acc_cyc - prev), 64'(BW + 1));
      prev = acc_cyc;
    end
    start = 1'b0;
    wait_idle();

    // Random start pulses and bin churn, including during conversion.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom % 3 == 0);
      bin = BW'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();

    // Abort mid-conversion.
    issue(200);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    issue(37);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
